// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - Wishbone burst master with retry, error and timeout handling
// One transfer per accepted start: linear incrementing burst, registered bus outputs.
module wb_burst_master #(
   parameter int DW        = 32,
   parameter int AW        = 32,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 255,
   parameter int RETRY_MAX = 3,
   localparam int LW       = $clog2(MAX_BURST + 1)
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic            wb_we_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic [2:0]      wb_cti_o,
   output logic [1:0]      wb_bte_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i,
   input  logic            start,
   input  logic [AW-1:0]   address,
   input  logic [DW/8-1:0] selection,
   input  logic            write,
   input  logic [LW-1:0]   length,
   input  logic [DW-1:0]   wr_data,
   output logic            wr_next,
   output logic [DW-1:0]   rd_data,
   output logic            rd_valid,
   output logic            active,
   output logic            done,
   output logic [1:0]      status
);

   localparam int RW = $clog2(RETRY_MAX + 2);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_OK         = 2'b00;
   localparam logic [1:0] ST_ERR        = 2'b01;
   localparam logic [1:0] ST_RETRY_FAIL = 2'b10;
   localparam logic [1:0] ST_TIMEOUT    = 2'b11;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_DONE} state_t;

   state_t        state;
   logic [LW-1:0] beats_left;
   logic [LW-1:0] len_eff;
   logic [RW-1:0] retry_cnt;
   logic [TW-1:0] to_cnt;

   always_comb begin
      len_eff = length;
      if (length == '0)
         len_eff = LW'(1);
      else if (length > LW'(MAX_BURST))
         len_eff = LW'(MAX_BURST);
   end

   // Only a clean ack (no err/rty in the same cycle) consumes a write beat.
   assign wr_next  = (state == S_BUS) && wb_ack_i && !wb_err_i && !wb_rty_i && wb_we_o;
   assign wb_dat_o = (wb_stb_o && wb_we_o) ? wr_data : '0;
   assign wb_bte_o = 2'b00;

   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         state      <= S_IDLE;
         wb_adr_o   <= '0;
         wb_sel_o   <= '0;
         wb_we_o    <= 1'b0;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_cti_o   <= 3'b000;
         beats_left <= '0;
         retry_cnt  <= '0;
         to_cnt     <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         active     <= 1'b0;
         done       <= 1'b0;
         status     <= ST_OK;
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  wb_adr_o   <= address;
                  wb_sel_o   <= selection;
                  wb_we_o    <= write;
                  beats_left <= len_eff;
                  wb_cti_o   <= (len_eff == LW'(1)) ? CTI_CLASSIC : CTI_INCR;
                  wb_cyc_o   <= 1'b1;
                  wb_stb_o   <= 1'b1;
                  active     <= 1'b1;
                  status     <= ST_OK;
                  retry_cnt  <= '0;
                  to_cnt     <= '0;
                  state      <= S_BUS;
               end
            end
            S_BUS: begin
               if (wb_err_i) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  status   <= ST_ERR;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end else if (wb_rty_i) begin
                  to_cnt   <= '0;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  if (retry_cnt == RW'(RETRY_MAX)) begin
                     status <= ST_RETRY_FAIL;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     retry_cnt <= retry_cnt + RW'(1);
                     state     <= S_BACKOFF;
                  end
               end else if (wb_ack_i) begin
                  to_cnt     <= '0;
                  retry_cnt  <= '0;
                  wb_adr_o   <= wb_adr_o + AW'(DW / 8);
                  beats_left <= beats_left - LW'(1);
                  if (!wb_we_o) begin
                     rd_data  <= wb_dat_i;
                     rd_valid <= 1'b1;
                  end
                  if (beats_left == LW'(1)) begin
                     wb_cyc_o <= 1'b0;
                     wb_stb_o <= 1'b0;
                     done     <= 1'b1;
                     state    <= S_DONE;
                  end else if (beats_left == LW'(2)) begin
                     wb_cti_o <= CTI_END;
                  end
               end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  status   <= ST_TIMEOUT;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_BACKOFF: begin
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               state    <= S_BUS;
            end
            S_DONE: begin
               active <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - directed self-checking bench for wb_burst_master
module tb_wb_burst_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MB = 16;
   localparam int LW = $clog2(MB + 1);

   logic            wb_clk = 1'b0;
   logic            wb_rst = 1'b0;
   logic [AW-1:0]   wb_adr_o;
   logic [DW-1:0]   wb_dat_o;
   logic [DW/8-1:0] wb_sel_o;
   logic            wb_we_o, wb_cyc_o, wb_stb_o;
   logic [2:0]      wb_cti_o;
   logic [1:0]      wb_bte_o;
   logic [DW-1:0]   wb_dat_i = '0;
   logic            wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
   logic            start = 1'b0;
   logic [AW-1:0]   address = '0;
   logic [DW/8-1:0] selection = '0;
   logic            write = 1'b0;
   logic [LW-1:0]   length = '0;
   logic [DW-1:0]   wr_data = '0;
   logic            wr_next;
   logic [DW-1:0]   rd_data;
   logic            rd_valid, active, done;
   logic [1:0]      status;

   int n_cmp = 0;
   int n_err = 0;

   wb_burst_master #(.DW(DW), .AW(AW), .MAX_BURST(MB), .TIMEOUT(8), .RETRY_MAX(3)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
      .start(start), .address(address), .selection(selection), .write(write),
      .length(length), .wr_data(wr_data), .wr_next(wr_next),
      .rd_data(rd_data), .rd_valid(rd_valid), .active(active),
      .done(done), .status(status)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] len);
      address   = a;
      selection = 4'hF;
      write     = w;
      length    = len;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   initial begin
      int beats;
      logic [2:0] last_cti;

      // Reset state
      step();
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_cti", {wb_cti_o, wb_bte_o}, 0);
      chk("rst_out", {active, done, rd_valid, status}, 0);
      wb_rst = 1'b1;
      step();

      // Single write, zero-wait
      wr_data = 32'hDEADBEEF;
      launch(32'h9000_0000, 1'b1, LW'(1));
      chk("w1_cycstb", {wb_cyc_o, wb_stb_o, wb_we_o, active}, 4'hF);
      chk("w1_cti", wb_cti_o, 3'b000);
      chk("w1_adr", wb_adr_o, 32'h9000_0000);
      chk("w1_sel", wb_sel_o, 4'hF);
      chk("w1_dat", wb_dat_o, 32'hDEADBEEF);
      wb_ack_i = 1'b1;
      #1 chk("w1_wr_next", wr_next, 1);
      step();
      wb_ack_i = 1'b0;
      chk("w1_done", {wb_cyc_o, wb_stb_o, done, active}, 4'b0011);
      chk("w1_status", status, 2'b00);
      step();
      chk("w1_idle", {done, active}, 0);

      // 4-beat read, zero-wait
      launch(32'h9000_0000, 1'b0, LW'(4));
      chk("r4_we", wb_we_o, 0);
      wb_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("r4_stb", wb_stb_o, 1);
         chk("r4_adr", wb_adr_o, 32'h9000_0000 + 4 * i);
         chk("r4_cti", wb_cti_o, (i == 3) ? 3'b111 : 3'b010);
         wb_dat_i = 32'h1000 + i;
         step();
         chk("r4_rd_valid", rd_valid, 1);
         chk("r4_rd_data", rd_data, 32'h1000 + i);
      end
      wb_ack_i = 1'b0;
      chk("r4_done", {wb_cyc_o, done, status}, 4'b0100);
      step();
      chk("r4_idle", {active, rd_valid}, 0);

      // Two retries then ack
      wr_data = 32'h11;
      launch(32'h9000_0010, 1'b1, LW'(1));
      for (int k = 0; k < 2; k++) begin
         wb_rty_i = 1'b1;
         step();
         wb_rty_i = 1'b0;
         chk("rty2_backoff", {wb_cyc_o, wb_stb_o, done}, 0);
         step();
         chk("rty2_reissue", {wb_cyc_o, wb_stb_o}, 2'b11);
         chk("rty2_adr", wb_adr_o, 32'h9000_0010);
      end
      wb_ack_i = 1'b1;
      step();
      wb_ack_i = 1'b0;
      chk("rty2_done", {done, status}, 3'b100);
      step();

      // Four retries -> retry failure
      launch(32'h9000_0020, 1'b1, LW'(1));
      for (int k = 0; k < 3; k++) begin
         wb_rty_i = 1'b1;
         step();
         wb_rty_i = 1'b0;
         chk("rty4_backoff", {wb_cyc_o, done}, 0);
         step();
         chk("rty4_reissue", wb_stb_o, 1);
      end
      wb_rty_i = 1'b1;
      step();
      wb_rty_i = 1'b0;
      chk("rty4_abort", {wb_cyc_o, done, status}, 4'b0110);
      step();
      chk("rty4_idle", active, 0);

      // err on beat 2 of 4, with rty and ack also asserted
      launch(32'h9000_0100, 1'b0, LW'(4));
      wb_ack_i = 1'b1;
      step();
      chk("err_beat2_adr", wb_adr_o, 32'h9000_0104);
      wb_err_i = 1'b1;
      wb_rty_i = 1'b1;
      step();
      {wb_ack_i, wb_err_i, wb_rty_i} = 3'b000;
      chk("err_abort", {wb_cyc_o, done, rd_valid, status}, 5'b01001);
      step();
      chk("err_no_more", {wb_stb_o, active}, 0);

      // Silent slave -> timeout after 8 strobe cycles; start ignored
      launch(32'h0000_0000, 1'b1, LW'(2));
      chk("to_status_clear", status, 2'b00);
      for (int i = 0; i < 8; i++) begin
         chk("to_stb", wb_stb_o, 1);
         chk("to_adr", wb_adr_o, 0);
         if (i == 3) begin
            address = 32'h5555_0000;
            start   = 1'b1;
         end
         step();
         start = 1'b0;
      end
      chk("to_abort", {wb_cyc_o, done, status}, 4'b0111);
      step();
      chk("to_idle", {active, status}, 3'b011);

      // Reset during beat 3
      launch(32'h9000_0200, 1'b1, LW'(4));
      chk("rst_mid_status", status, 2'b00);
      wb_ack_i = 1'b1;
      step();
      step();
      wb_ack_i = 1'b0;
      chk("rst_mid_adr", wb_adr_o, 32'h9000_0208);
      #2 wb_rst = 1'b0;
      #1;
      chk("rst_mid_bus", {wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o}, 0);
      chk("rst_mid_out", {active, done, status, wb_cti_o}, 0);
      step();
      chk("rst_mid_nodone", done, 0);
      wb_rst = 1'b1;
      step();

      // Fresh transfer after reset; length 0 acts as 1
      launch(32'h9000_0300, 1'b0, LW'(0));
      chk("len0_cti", wb_cti_o, 3'b000);
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hCAFE;
      step();
      wb_ack_i = 1'b0;
      chk("len0_done", {done, status}, 3'b100);
      chk("len0_rd", rd_data, 32'hCAFE);
      step();

      // Oversized length clamps to MAX_BURST
      launch(32'h0000_0000, 1'b0, LW'(31));
      wb_ack_i = 1'b1;
      beats    = 0;
      last_cti = 3'b000;
      for (int i = 0; i < 40 && wb_stb_o; i++) begin
         beats++;
         last_cti = wb_cti_o;
         step();
      end
      wb_ack_i = 1'b0;
      chk("clamp_beats", beats, MB);
      chk("clamp_last_cti", last_cti, 3'b111);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per transfer.
REQ-004 SHALL have parameter TIMEOUT, default 255, idle cycles per beat before abort.
REQ-005 SHALL have parameter RETRY_MAX, default 3, retries allowed per beat.
REQ-006 SHALL have reset wb_rst, asynchronous, active-low; clock wb_clk.
REQ-007 SHALL have ports:
- wb_clk  in  1  bus clock.
- wb_rst  in  1  async active-low reset.
- wb_adr_o  out  AW  byte address.
- wb_dat_o  out  DW  write data.
- wb_sel_o  out  DW/8  byte select.
- wb_we_o / wb_cyc_o / wb_stb_o  out  1 each  write enable, cycle, strobe.
- wb_cti_o  out  3  cycle type.
- wb_bte_o  out  2  burst type.
- wb_dat_i  in  DW  read data.
- wb_ack_i / wb_err_i / wb_rty_i  in  1 each  slave terminations.
- start  in  1  launch request.
- address  in  AW  first-beat address.
- selection  in  DW/8  byte select, all beats.
- write  in  1  1 = write, 0 = read.
- length  in  $clog2(MAX_BURST+1)  beat count.
- wr_data  in  DW  current write beat.
- wr_next  out  1  pulse: wr_data consumed, present next beat.
- rd_data  out  DW  captured read beat.
- rd_valid  out  1  pulse: rd_data valid.
- active  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 OK, 01 ERR, 10 RETRY_FAIL, 11 TIMEOUT.

Function
REQ-008 SHALL implement FSM IDLE -> BUS -> (BACKOFF -> BUS)* -> DONE -> IDLE; all bus outputs registered.
REQ-009 SHALL, in IDLE, latch address/selection/write/length on a wb_clk edge with start=1, and assert cyc/stb on the following cycle (1-cycle launch latency).
REQ-010 SHALL treat length=0 as 1 and length>MAX_BURST as MAX_BURST.
REQ-011 SHALL drive cti=000 for a 1-beat transfer; otherwise 010 on every beat except the last, which uses 111; bte always 00.
REQ-012 SHALL, on ack in BUS, advance adr by DW/8 (wrapping modulo 2^AW) and decrement the beat count; with a zero-wait slave, consecutive beats complete on consecutive cycles.
REQ-013 SHALL, on a read ack, register wb_dat_i into rd_data and pulse rd_valid one cycle later.
REQ-014 SHALL, on a write ack, pulse wr_next in the ack cycle, and drive wb_dat_o from wr_data while stb is asserted.
REQ-015 SHALL, on rty, drop cyc/stb for one BACKOFF cycle, then reissue the same beat; on the (RETRY_MAX+1)th rty, abort with status 10.
REQ-016 SHALL reset the retry counter on every ack.
REQ-017 SHALL, on err, abort immediately with status 01.
REQ-018 SHALL count cycles in BUS with no termination, resetting on any termination; at count TIMEOUT it SHALL abort with status 11.
REQ-019 SHALL resolve simultaneous terminations with priority err > rty > ack.
REQ-020 SHALL, on abort or after the last ack, deassert cyc/stb next cycle, enter DONE, pulse done for one cycle, and return to IDLE.
REQ-021 SHALL assert active from the launch edge through the DONE cycle inclusive.
REQ-022 SHALL ignore start while not in IDLE.
REQ-023 SHALL hold status until the next accepted start, then clear it to 00.

Reset
REQ-024 SHALL, when wb_rst=0, asynchronously force IDLE and drive every output to 0, including adr/dat/sel/cti/bte, rd_data and status; all counters clear.
REQ-025 SHALL, if reset asserts mid-burst, drop cyc/stb immediately and emit no done pulse.

Verification
REQ-026 Single write 0x9000_0000 / 0xDEADBEEF / sel F, zero-wait slave -> cyc/stb one cycle, cti 000, we=1, done one cycle after ack, status 00.
REQ-027 4-beat read from 0x9000_0000 -> adr 0x..00/04/08/0C on consecutive cycles, cti 010,010,010,111, four rd_valid pulses.
REQ-028 Slave returns rty twice, then ack -> two BACKOFF gaps, beat reissued at same address, status 00; with four rty -> status 10.
REQ-029 err on beat 2 of 4 -> cyc drops next cycle, done pulse, status 01, no further beats.
REQ-030 Slave never responds, TIMEOUT=8 -> abort after 8 stb cycles, status 11; start during the transfer is ignored.
REQ-031 wb_rst low during beat 3 -> all outputs 0 asynchronously, no done pulse; a new transfer succeeds after release.
